regbank_writeback_unit: RTL

- Writer-side companion of the 8x8-bit register bank.
- Buffers results from the execute stage in a small FIFO and drains them onto the bank's write port, one write per clock.
- Publishes a pending-destination scoreboard for hazard detection.
- Optionally forwards buffered data to operand readers.

---
 rtl/regbank_writeback_unit_pkg.sv | 11 +
 rtl/regbank_writeback_unit_wb_fifo.sv | 57 +++++
 rtl/regbank_writeback_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/regbank_writeback_unit_pkg.sv
// Shared widths and FIFO entry type for the register-bank writeback unit.
package regbank_writeback_unit_pkg;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/regbank_writeback_unit_wb_fifo.sv
// Result FIFO: pointers, count, storage; exposes entries in age order (oldest at index 0).
module regbank_writeback_unit_wb_fifo
  import regbank_writeback_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_Push,
  input  entry_t               i_PushEntry,
  input  logic                 i_Pop,
  output logic                 o_Full,
  output logic                 o_Empty,
  output entry_t [DEPTH-1:0]   o_AgeEntry,
  output logic   [DEPTH-1:0]   o_AgeValid
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] wptr;
  logic   [PTR_W-1:0] rptr;
  logic   [CNT_W-1:0] count;
  logic               doPush;
  logic               doPop;

  assign o_Full  = (count == CNT_W'(DEPTH));
  assign o_Empty = (count == '0);
  assign doPush  = i_Push & ~o_Full;
  assign doPop   = i_Pop & ~o_Empty;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wptr] <= i_PushEntry;
        wptr      <= wptr + 1'b1;
      end
      if (doPop) rptr <= rptr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_AgeEntry[i] = mem[PTR_W'(32'(rptr) + i)];
      o_AgeValid[i] = (i < 32'(count));
    end
  end
endmodule

// File: rtl/regbank_writeback_unit.sv
// Writeback unit: buffers execute results and drains one bank write per clock.
// Define WB_FORWARD_EN to enable operand forwarding from buffered/in-flight writes.
module regbank_writeback_unit
  import regbank_writeback_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_ResultValid,
  input  logic [ADDR_W-1:0]   i_ResultDest,
  input  logic [DATA_W-1:0]   i_ResultData,
  output logic                o_ResultReady,
  output logic [ADDR_W-1:0]   o_AddrRegDest,
  output logic [DATA_W-1:0]   o_WriteData,
  output logic                o_WriteBack,
  output logic [NUM_REGS-1:0] o_Pending,
  input  logic [ADDR_W-1:0]   i_QueryAddr1,
  input  logic [ADDR_W-1:0]   i_QueryAddr2,
  output logic                o_FwdHit1,
  output logic [DATA_W-1:0]   o_FwdData1,
  output logic                o_FwdHit2,
  output logic [DATA_W-1:0]   o_FwdData2
);
  entry_t [DEPTH-1:0] ageEntry;
  logic   [DEPTH-1:0] ageValid;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               pop;

  assign o_ResultReady = ~fifoFull;
  assign pop           = ~fifoEmpty;

  regbank_writeback_unit_wb_fifo #(.DEPTH(DEPTH)) wbFifo (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_Push      (i_ResultValid),
    .i_PushEntry ('{dest: i_ResultDest, data: i_ResultData}),
    .i_Pop       (pop),
    .o_Full      (fifoFull),
    .o_Empty     (fifoEmpty),
    .o_AgeEntry  (ageEntry),
    .o_AgeValid  (ageValid)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_WriteBack   <= 1'b0;
      o_AddrRegDest <= '0;
      o_WriteData   <= '0;
    end else if (pop) begin
      o_WriteBack   <= 1'b1;
      o_AddrRegDest <= ageEntry[0].dest;
      o_WriteData   <= ageEntry[0].data;
    end else begin
      o_WriteBack   <= 1'b0;
    end
  end

  // The in-flight write counts as pending until the bank has actually taken it.
  always_comb begin
    o_Pending = '0;
    if (o_WriteBack) o_Pending[o_AddrRegDest] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ageValid[i]) o_Pending[ageEntry[i].dest] = 1'b1;
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to newest so the youngest match is the one left standing.
  always_comb begin
    o_FwdData1 = '0;
    o_FwdData2 = '0;
    if (o_WriteBack && o_AddrRegDest == i_QueryAddr1) o_FwdData1 = o_WriteData;
    if (o_WriteBack && o_AddrRegDest == i_QueryAddr2) o_FwdData2 = o_WriteData;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ageValid[i] && ageEntry[i].dest == i_QueryAddr1) o_FwdData1 = ageEntry[i].data;
      if (ageValid[i] && ageEntry[i].dest == i_QueryAddr2) o_FwdData2 = ageEntry[i].data;
    end
  end
  assign o_FwdHit1 = o_Pending[i_QueryAddr1];
  assign o_FwdHit2 = o_Pending[i_QueryAddr2];
`else
  logic unusedFwd;
  assign unusedFwd  = ^{i_QueryAddr1, i_QueryAddr2, ageEntry};
  assign o_FwdHit1  = 1'b0;
  assign o_FwdData1 = '0;
  assign o_FwdHit2  = 1'b0;
  assign o_FwdData2 = '0;
`endif
endmodule
